// File: rtl/spu_regfile_wb_if.sv
// spu_regfile_wb_if: operand-read and writeback bus of the shared SPU register file.
// Bit numbering is big-endian ([0] is the MSB) to match the SPU datapath.
//   Read addresses : ra/rb/rc_addr_ev, ra/rb/rc_addr_od  [0:6]
//   Read operands  : ra/rb/rc_ev, ra/rb/rc_od            [0:127]
//   Even writeback : rt_ev_wb [0:127], rt_addr_ev_wb [0:6], reg_write_ev_wb
//   Odd writeback  : rt_od_wb [0:127], rt_addr_od_wb [0:6], reg_write_od_wb
//   Status         : write_conflict (1-cycle pulse), conflict_count [0:7]
// master = pipeline side (drives addresses and writebacks), slave = register file.
interface spu_regfile_wb_if;
  logic [0:6]   ra_addr_ev;
  logic [0:6]   rb_addr_ev;
  logic [0:6]   rc_addr_ev;
  logic [0:6]   ra_addr_od;
  logic [0:6]   rb_addr_od;
  logic [0:6]   rc_addr_od;
  logic [0:127] ra_ev;
  logic [0:127] rb_ev;
  logic [0:127] rc_ev;
  logic [0:127] ra_od;
  logic [0:127] rb_od;
  logic [0:127] rc_od;
  logic [0:127] rt_ev_wb;
  logic [0:6]   rt_addr_ev_wb;
  logic         reg_write_ev_wb;
  logic [0:127] rt_od_wb;
  logic [0:6]   rt_addr_od_wb;
  logic         reg_write_od_wb;
  logic         write_conflict;
  logic [0:7]   conflict_count;

  modport master (
    output ra_addr_ev, rb_addr_ev, rc_addr_ev, ra_addr_od, rb_addr_od, rc_addr_od,
    output rt_ev_wb, rt_addr_ev_wb, reg_write_ev_wb,
    output rt_od_wb, rt_addr_od_wb, reg_write_od_wb,
    input  ra_ev, rb_ev, rc_ev, ra_od, rb_od, rc_od,
    input  write_conflict, conflict_count
  );

  modport slave (
    input  ra_addr_ev, rb_addr_ev, rc_addr_ev, ra_addr_od, rb_addr_od, rc_addr_od,
    input  rt_ev_wb, rt_addr_ev_wb, reg_write_ev_wb,
    input  rt_od_wb, rt_addr_od_wb, reg_write_od_wb,
    output ra_ev, rb_ev, rc_ev, ra_od, rb_od, rc_od,
    output write_conflict, conflict_count
  );
endinterface

// File: rtl/spu_regfile_wb.sv
// spu_regfile_wb: shared SPU register file (128 x 128 bit) with writeback stage.
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous active-low; clears array, operand outputs and conflict state
//   bus   - spu_regfile_wb_if.slave: six registered read ports (even/odd ra, rb, rc),
//           even/odd writeback buses, write_conflict pulse and saturating conflict_count
// Reads register on the same edge as writes; a write retiring this cycle is bypassed
// into the read so consumers never see stale data. Odd pipe is later in program
// order, so it wins both the array write and the bypass on an address collision.
module spu_regfile_wb (
  input logic              clk,
  input logic              reset,
  spu_regfile_wb_if.slave  bus
);

  localparam int REGS  = 128;
  localparam int WIDTH = 128;
  localparam int PORTS = 6;

  logic [0:WIDTH-1] mem_r [0:REGS-1];
  logic [0:6]       rd_addr_s [0:PORTS-1];
  logic [0:WIDTH-1] rd_data_s [0:PORTS-1];
  logic [0:WIDTH-1] rd_q_r    [0:PORTS-1];
  logic             conflict_s;
  logic             write_conflict_r;
  logic [0:7]       conflict_count_r;

  // Port order: 0..2 = even ra/rb/rc, 3..5 = odd ra/rb/rc
  assign rd_addr_s[0] = bus.ra_addr_ev;
  assign rd_addr_s[1] = bus.rb_addr_ev;
  assign rd_addr_s[2] = bus.rc_addr_ev;
  assign rd_addr_s[3] = bus.ra_addr_od;
  assign rd_addr_s[4] = bus.rb_addr_od;
  assign rd_addr_s[5] = bus.rc_addr_od;

  // Same-address dual write detection
  always_comb begin
    conflict_s = 1'b0;
    if (bus.reg_write_ev_wb && bus.reg_write_od_wb &&
        (bus.rt_addr_ev_wb == bus.rt_addr_od_wb)) begin
      conflict_s = 1'b1;
    end else begin
      conflict_s = 1'b0;
    end
  end

  // Read mux with write bypass; odd hit takes priority over even hit
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      rd_data_s[i] = mem_r[rd_addr_s[i]];
      if (bus.reg_write_od_wb && (bus.rt_addr_od_wb == rd_addr_s[i])) begin
        rd_data_s[i] = bus.rt_od_wb;
      end else if (bus.reg_write_ev_wb && (bus.rt_addr_ev_wb == rd_addr_s[i])) begin
        rd_data_s[i] = bus.rt_ev_wb;
      end else begin
        rd_data_s[i] = mem_r[rd_addr_s[i]];
      end
    end
  end

  // Register array; odd write is issued last so it wins a same-address collision
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REGS; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (bus.reg_write_ev_wb) begin
        mem_r[bus.rt_addr_ev_wb] <= bus.rt_ev_wb;
      end
      if (bus.reg_write_od_wb) begin
        mem_r[bus.rt_addr_od_wb] <= bus.rt_od_wb;
      end
    end
  end

  // Registered operand outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PORTS; i++) begin
        rd_q_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        rd_q_r[i] <= rd_data_s[i];
      end
    end
  end

  // Conflict pulse and saturating conflict counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_conflict_r <= 1'b0;
      conflict_count_r <= 8'd0;
    end else begin
      write_conflict_r <= conflict_s;
      if (conflict_s && (conflict_count_r != 8'd255)) begin
        conflict_count_r <= conflict_count_r + 8'd1;
      end
    end
  end

  assign bus.ra_ev          = rd_q_r[0];
  assign bus.rb_ev          = rd_q_r[1];
  assign bus.rc_ev          = rd_q_r[2];
  assign bus.ra_od          = rd_q_r[3];
  assign bus.rb_od          = rd_q_r[4];
  assign bus.rc_od          = rd_q_r[5];
  assign bus.write_conflict = write_conflict_r;
  assign bus.conflict_count = conflict_count_r;

endmodule

// File: tb/tb_spu_regfile_wb.sv
// tb_spu_regfile_wb: directed self-checking bench for spu_regfile_wb.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_spu_regfile_wb;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  localparam logic [0:127] V_R5  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [0:127] V_ONE = 128'h00000000000000000000000000000001;
  localparam logic [0:127] V_FF0 = 128'hFFFFFFFFFFFFFFFF0000000000000000;
  localparam logic [0:127] V_AA  = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;
  localparam logic [0:127] V_55  = 128'h55555555555555555555555555555555;
  localparam logic [0:127] V_R7  = 128'h00000000000000000000000012345678;
  localparam logic [0:127] V_DEA = 128'hDEADDEADDEADDEADDEADDEADDEADDEAD;
  localparam logic [0:127] V_77  = 128'h77777777777777777777777777777777;
  localparam logic [0:127] V_44  = 128'h44444444444444444444444444444444;
  localparam logic [0:127] V_30  = 128'h30303030303030303030303030303030;
  localparam logic [0:127] V_31  = 128'h31313131313131313131313131313131;
  localparam logic [0:127] ZERO  = 128'h0;

  spu_regfile_wb_if bus ();

  spu_regfile_wb dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk128(input string tag, input logic [0:127] obs, input logic [0:127] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [0:7] obs, input logic [0:7] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all6(input string tag, input logic [0:127] exp);
    chk128({tag, "_ra_ev"}, bus.ra_ev, exp);
    chk128({tag, "_rb_ev"}, bus.rb_ev, exp);
    chk128({tag, "_rc_ev"}, bus.rc_ev, exp);
    chk128({tag, "_ra_od"}, bus.ra_od, exp);
    chk128({tag, "_rb_od"}, bus.rb_od, exp);
    chk128({tag, "_rc_od"}, bus.rc_od, exp);
  endtask

  task automatic idle_wb();
    bus.reg_write_ev_wb = 1'b0;
    bus.reg_write_od_wb = 1'b0;
    bus.rt_ev_wb        = ZERO;
    bus.rt_od_wb        = ZERO;
    bus.rt_addr_ev_wb   = 7'd0;
    bus.rt_addr_od_wb   = 7'd0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    idle_wb();
    bus.ra_addr_ev = 7'd0;   bus.rb_addr_ev = 7'd63; bus.rc_addr_ev = 7'd127;
    bus.ra_addr_od = 7'd127; bus.rb_addr_od = 7'd63; bus.rc_addr_od = 7'd0;

    // Reset held for 3 cycles; outputs must already be zero
    tick(); tick(); tick();
    chk_all6("in_reset", ZERO);
    chk8("in_reset_count", bus.conflict_count, 8'd0);
    chk1("in_reset_conflict", bus.write_conflict, 1'b0);
    reset = 1'b1;
    tick();
    chk_all6("post_reset_read", ZERO);
    chk8("post_reset_count", bus.conflict_count, 8'd0);

    // Even write r5 at edge N, read at edge N+1
    bus.reg_write_ev_wb = 1'b1; bus.rt_addr_ev_wb = 7'd5; bus.rt_ev_wb = V_R5;
    bus.ra_addr_ev = 7'd0;
    tick();
    chk128("r5_not_yet_on_r0", bus.ra_ev, ZERO);
    idle_wb();
    bus.ra_addr_ev = 7'd5;
    tick();
    chk128("r5_read", bus.ra_ev, V_R5);
    for (int i = 0; i < 10; i++) tick();
    chk128("r5_persist", bus.ra_ev, V_R5);

    // Even write r9 = 1, bypassed to ra_od at the same edge
    bus.reg_write_ev_wb = 1'b1; bus.rt_addr_ev_wb = 7'd9; bus.rt_ev_wb = V_ONE;
    bus.ra_addr_od = 7'd9;
    tick();
    chk128("ev_bypass_r9", bus.ra_od, V_ONE);
    // Odd write r9 bypassed to rb_ev and rc_od at the same edge
    idle_wb();
    bus.reg_write_od_wb = 1'b1; bus.rt_addr_od_wb = 7'd9; bus.rt_od_wb = V_FF0;
    bus.rb_addr_ev = 7'd9; bus.rc_addr_od = 7'd9;
    tick();
    chk128("od_bypass_rb_ev", bus.rb_ev, V_FF0);
    chk128("od_bypass_rc_od", bus.rc_od, V_FF0);
    chk128("od_bypass_ra_od", bus.ra_od, V_FF0);
    idle_wb();
    tick();
    chk128("r9_from_array", bus.rb_ev, V_FF0);

    // Dual write to different addresses: both commit, no conflict
    bus.reg_write_ev_wb = 1'b1; bus.rt_addr_ev_wb = 7'd30; bus.rt_ev_wb = V_30;
    bus.reg_write_od_wb = 1'b1; bus.rt_addr_od_wb = 7'd31; bus.rt_od_wb = V_31;
    tick();
    chk1("diff_addr_no_conflict", bus.write_conflict, 1'b0);
    idle_wb();
    bus.ra_addr_ev = 7'd30; bus.ra_addr_od = 7'd31;
    tick();
    chk128("dual_r30", bus.ra_ev, V_30);
    chk128("dual_r31", bus.ra_od, V_31);

    // Collision on r20: odd data wins in both bypass and array
    bus.reg_write_ev_wb = 1'b1; bus.rt_addr_ev_wb = 7'd20; bus.rt_ev_wb = V_AA;
    bus.reg_write_od_wb = 1'b1; bus.rt_addr_od_wb = 7'd20; bus.rt_od_wb = V_55;
    bus.ra_addr_ev = 7'd20;
    tick();
    chk1("collide_pulse", bus.write_conflict, 1'b1);
    chk8("collide_count1", bus.conflict_count, 8'd1);
    chk128("collide_bypass", bus.ra_ev, V_55);
    idle_wb();
    tick();
    chk1("collide_pulse_end", bus.write_conflict, 1'b0);
    chk128("collide_array", bus.ra_ev, V_55);
    chk8("collide_count_hold", bus.conflict_count, 8'd1);

    // 300 back-to-back collisions: counter saturates at 255
    bus.reg_write_ev_wb = 1'b1; bus.rt_addr_ev_wb = 7'd20; bus.rt_ev_wb = V_AA;
    bus.reg_write_od_wb = 1'b1; bus.rt_addr_od_wb = 7'd20; bus.rt_od_wb = V_55;
    tick(); tick();
    chk1("b2b_conflict_held", bus.write_conflict, 1'b1);
    chk8("b2b_count3", bus.conflict_count, 8'd3);
    for (int i = 0; i < 298; i++) tick();
    chk8("count_saturated", bus.conflict_count, 8'd255);
    idle_wb();
    tick();
    chk1("sat_pulse_end", bus.write_conflict, 1'b0);
    chk8("count_sat_hold", bus.conflict_count, 8'd255);

    // Disabled write to r7: no commit and no bypass
    bus.reg_write_ev_wb = 1'b1; bus.rt_addr_ev_wb = 7'd7; bus.rt_ev_wb = V_R7;
    tick();
    idle_wb();
    bus.rt_addr_ev_wb = 7'd7; bus.rt_ev_wb = V_DEA;
    bus.rc_addr_ev = 7'd7;
    tick();
    chk128("disabled_no_bypass", bus.rc_ev, V_R7);
    tick();
    chk128("disabled_no_commit", bus.rc_ev, V_R7);

    // Mid-stream reset with a write to r4 pending
    bus.reg_write_ev_wb = 1'b1; bus.rt_addr_ev_wb = 7'd3; bus.rt_ev_wb = V_77;
    bus.ra_addr_ev = 7'd3;
    tick();
    chk128("r3_written", bus.ra_ev, V_77);
    bus.rt_addr_ev_wb = 7'd4; bus.rt_ev_wb = V_44;
    #2;
    reset = 1'b0;
    #1;
    chk128("async_clear_ra_ev", bus.ra_ev, ZERO);
    chk128("async_clear_rc_ev", bus.rc_ev, ZERO);
    chk128("async_clear_rb_ev", bus.rb_ev, ZERO);
    chk8("async_clear_count", bus.conflict_count, 8'd0);
    tick();
    reset = 1'b1;
    idle_wb();
    bus.ra_addr_ev = 7'd3; bus.rb_addr_ev = 7'd4; bus.ra_addr_od = 7'd5;
    tick();
    chk128("r3_after_reset", bus.ra_ev, ZERO);
    chk128("r4_discarded", bus.rb_ev, ZERO);
    chk128("r5_after_reset", bus.ra_od, ZERO);
    chk8("count_after_reset", bus.conflict_count, 8'd0);
    chk1("conflict_after_reset", bus.write_conflict, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spu_regfile_wb.md
# spu_regfile_wb

Shared SPU register file and writeback stage: 128 × 128-bit registers, written by the even- and odd-pipe writeback buses and read through six registered ports that feed the RF/FWD operand inputs (ra, rb, rc) of both pipes. It sits directly downstream of the execution units' WB outputs (rt_wb / rt_addr_wb / reg_write_wb) and directly upstream of their operand inputs. It closes the loop with same-cycle write-to-read bypass, and detects and counts dual-pipe write collisions.

## Interface
- REGS, 128, number of architectural registers; address width 7 bits
- WIDTH, 128, register width in bits, big-endian numbering [0:WIDTH-1]
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low (asserted when 0); clears all state immediately
- ra_addr_ev, rb_addr_ev, rc_addr_ev  in  [0:6] each  even-pipe read addresses
- ra_addr_od, rb_addr_od, rc_addr_od  in  [0:6] each  odd-pipe read addresses
- ra_ev, rb_ev, rc_ev  out  [0:127] each  registered even-pipe operands
- ra_od, rb_od, rc_od  out  [0:127] each  registered odd-pipe operands
- rt_ev_wb  in  [0:127]  even-pipe writeback data
- rt_addr_ev_wb  in  [0:6]  even-pipe writeback address
- reg_write_ev_wb  in  1  even-pipe write enable
- rt_od_wb, rt_addr_od_wb, reg_write_od_wb  in  [0:127], [0:6], 1  odd-pipe writeback, same meaning
- write_conflict  out  1  registered one-cycle pulse: both pipes wrote the same address
- conflict_count  out  [0:7]  saturating count of conflicts since reset

## Operation
- Storage: array of REGS entries × WIDTH bits. All entries are 0 after reset. Register 0 is an ordinary register, not hard-wired.
- Writes: on each rising edge, commit rt_ev_wb to rt_addr_ev_wb if reg_write_ev_wb = 1, and commit rt_od_wb to rt_addr_od_wb if reg_write_od_wb = 1. When a write enable is 0, its address and data are don't-care.
- Dual write to different addresses: both commit.
- Dual write to the same address: odd-pipe data commits. Odd is the later instruction in program order.
  - write_conflict = 1 in the following cycle.
  - conflict_count increments by 1 and saturates at 255 (no wrap).
- Reads: each of the six ports registers its output on the rising edge. The value registered is:
  - odd-pipe write data, if an odd write hits the read address this cycle;
  - else even-pipe write data, if an even write hits the read address;
  - else the array entry.
  - This bypass guarantees a consumer never reads stale data for a result retiring in the same cycle.
- Any number of read ports may use the same address at once; every port returns an identical value.
- No stalls and no handshake. Every port is usable every cycle.

## Timing
- Read latency: 1 cycle. The address presented before edge N appears on the output after edge N and holds until edge N+1.
- Write visibility: data written at edge N reaches the array at edge N. Reads sampled at edge N already see it through the bypass; reads sampled at N+1 or later see it from the array.
- write_conflict is asserted for exactly one cycle per colliding edge. Back-to-back collisions hold it at 1.
- Reset (reset = 0, at any time including mid-stream):
  - All array entries, all six read outputs, write_conflict and conflict_count go to 0 asynchronously.
  - Writes presented while reset is asserted are discarded.
- First edge after release (reset = 1): normal operation. Reads of any address return 0 until that address is written.

## Test plan
- Reset check: assert reset for 3 cycles, release, read addresses 0, 63, 127 on all six ports -> every output 0; conflict_count = 0.
- Write then read: even writes 0x0123…CDEF to r5 at edge N; ra_addr_ev = 5 presented at edge N+1 -> ra_ev = 0x0123…CDEF after edge N+1. Also confirm value persists 10 cycles later.
- Bypass: odd writes 0xFFFF…0000 to r9 at edge N while rb_addr_ev = rc_addr_od = 9 at edge N; previous r9 = 0x1 -> both outputs = 0xFFFF…0000 after edge N, not 0x1.
- Collision: both pipes write r20 at edge N (even 0xAA…, odd 0x55…) -> write_conflict = 1 for one cycle; r20 reads 0x55…; conflict_count = 1. Repeat 300 times -> conflict_count = 255.
- Disabled write: reg_write_ev_wb = 0 with rt_addr_ev_wb = 7, data 0xDEAD… -> r7 unchanged, no bypass; reading r7 still returns its prior value.
- Reset mid-stream: write r3 = 0x77…, then drop reset between edges while a write to r4 is pending -> outputs 0 immediately. After release, r3 and r4 both read 0 and the counter is 0.
